mac_pe_multimode: RTL

Parametrised, run-time-configurable multiply-accumulate processing element for the systolic array. It is the successor to the fixed flow-through MAC cell. It adds three dataflow modes, valid qualification, weight-stationary preload chaining, an output-stationary local accumulator with drain, and optional saturation with a sticky overflow flag. One instance sits at each array grid point. Weights travel down columns, ifmaps travel across rows, and partial sums travel to the neighbour.

---
 rtl/mac_pe_multimode.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mac_pe_multimode.sv
// ----------------------------------------------------------------------------
// mac_pe_multimode : systolic-array MAC cell with FLOW / WS / OS dataflows,
//                    weight preload chaining, OS drain and optional saturation
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_pe_multimode #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,
  parameter bit SATURATE       = 1'b0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  input  logic                             w_load,
  input  logic                             drain,
  input  logic signed [W_BITWIDTH-1:0]     w_data_in,
  input  logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  input  logic signed [OFMAP_BITWIDTH-1:0] psum_in,
  output logic signed [W_BITWIDTH-1:0]     w_data_out,
  output logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  output logic signed [OFMAP_BITWIDTH-1:0] psum_out,
  output logic                             out_valid,
  output logic                             w_load_out,
  output logic                             ovf
);

  localparam int PW = IFMAP_BITWIDTH + W_BITWIDTH;
  localparam int OW = OFMAP_BITWIDTH;

  localparam logic [1:0] MODE_FLOW = 2'b00;
  localparam logic [1:0] MODE_WS   = 2'b01;
  localparam logic [1:0] MODE_OS   = 2'b10;

  localparam logic signed [OW-1:0] SUM_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SUM_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [W_BITWIDTH-1:0] w_stat;
  logic signed [OW-1:0]         acc;
  logic [1:0]                   mode_q;

  logic                 mode_chg;
  logic                 is_ws;
  logic                 is_os;
  logic signed [PW-1:0] prod_flow;
  logic signed [PW-1:0] prod_ws;
  logic signed [OW-1:0] prod_ext;
  logic signed [OW-1:0] addend;
  logic signed [OW:0]   sum_ext;
  logic                 sum_ovf;
  logic signed [OW-1:0] sum_res;

  assign mode_chg = (mode != mode_q);
  assign is_ws    = (mode == MODE_WS);
  assign is_os    = (mode == MODE_OS);

  assign prod_flow = PW'(w_data_in) * PW'(ifmap_data_in);
  assign prod_ws   = PW'(w_stat) * PW'(ifmap_data_in);
  assign prod_ext  = is_ws ? OW'(prod_ws) : OW'(prod_flow);
  assign addend    = is_os ? acc : psum_in;

  // One extra bit catches the carry out so overflow is a simple sign test.
  assign sum_ext = (OW+1)'(addend) + (OW+1)'(prod_ext);
  assign sum_ovf = sum_ext[OW] ^ sum_ext[OW-1];

  generate
    if (SATURATE) begin : g_sat
      assign sum_res = !sum_ovf     ? sum_ext[OW-1:0] :
                       sum_ext[OW]  ? SUM_MIN         : SUM_MAX;
    end else begin : g_wrap
      assign sum_res = sum_ext[OW-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_data_out     <= '0;
      ifmap_data_out <= '0;
      psum_out       <= '0;
      out_valid      <= 1'b0;
      w_load_out     <= 1'b0;
      ovf            <= 1'b0;
      w_stat         <= '0;
      acc            <= '0;
      mode_q         <= MODE_FLOW;
    end else begin
      mode_q     <= mode;
      w_load_out <= w_load;
      out_valid  <= 1'b0;

      if (mode_chg) begin
        // A mode switch only flushes state; the datapath idles for this cycle.
        acc <= '0;
        ovf <= 1'b0;
      end else if (is_ws) begin
        if (w_load) begin
          w_stat     <= w_data_in;
          w_data_out <= w_data_in;
        end
        if (in_valid) begin
          ifmap_data_out <= ifmap_data_in;
          psum_out       <= sum_res;
          out_valid      <= 1'b1;
          ovf            <= ovf | sum_ovf;
        end
      end else if (is_os) begin
        if (in_valid) begin
          w_data_out     <= w_data_in;
          ifmap_data_out <= ifmap_data_in;
        end
        if (drain) begin
          // Restart accumulation with the product arriving alongside the drain.
          psum_out  <= acc;
          out_valid <= 1'b1;
          acc       <= in_valid ? prod_ext : '0;
        end else if (in_valid) begin
          acc <= sum_res;
          ovf <= ovf | sum_ovf;
        end
      end else begin
        if (in_valid) begin
          w_data_out     <= w_data_in;
          ifmap_data_out <= ifmap_data_in;
          psum_out       <= sum_res;
          out_valid      <= 1'b1;
          ovf            <= ovf | sum_ovf;
        end
      end
    end
  end

endmodule

`default_nettype wire
